// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS data bus: word RAM plus a result FIFO
// drained over valid/ready. Define DMEM_ALIGN_CHECK_EN to reject misaligned stores.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] RESULT_ADDR = 32'h54,
    parameter logic [31:0] STATUS_ADDR = 32'h58
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        overflow,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          aligned;
    logic          sel_result, sel_status, sel_ram;
    logic          ram_we, push, pop, full, push_ok, drop, status_clr;

    logic [31:0]   ram      [DEPTH_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic          overflow_q;

    // Word-granular decode; the result and status ports shadow the RAM words
    // they overlap.
    assign word_addr  = dataaddr[31:2];
    assign ram_idx    = word_addr[AW-1:0];
    assign sel_result = (word_addr == RESULT_ADDR[31:2]);
    assign sel_status = !sel_result && (word_addr == STATUS_ADDR[31:2]);
    assign sel_ram    = !sel_result && !sel_status && (word_addr < 30'(DEPTH_WORDS));

    assign ram_we     = memwrite && aligned && sel_ram;
    assign push       = memwrite && aligned && sel_result;
    assign status_clr = memwrite && aligned && sel_status;

    assign res_valid  = (count != '0);
    assign res_data   = res_valid ? fifo_mem[rd_ptr] : '0;
    assign pop        = res_valid && res_ready;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign push_ok    = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign overflow   = overflow_q;

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalign_q;

    assign aligned  = (dataaddr[1:0] == 2'b00);
    assign misalign = misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (memwrite && !aligned) begin
            misalign_q <= 1'b1;
        end else if (status_clr) begin
            misalign_q <= 1'b0;
        end
    end
`else
    logic unused_addr_bits;

    assign aligned          = 1'b1;
    assign misalign         = 1'b0;
    assign unused_addr_bits = ^dataaddr[1:0];
`endif

    // NOTE: storage arrays carry no reset so they map onto plain RAM; the
    // FIFO is emptied by resetting its count and pointers instead.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= writedata;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr] <= writedata;
        end
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({push_ok, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= count_next;
            // A drop in the same cycle as a status clear leaves the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (status_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (aligned) begin
            if (sel_result) begin
                readdata = res_data;
            end else if (sel_status) begin
                readdata = {overflow_q, misalign, 22'b0, 8'(count)};
            end else if (sel_ram) begin
                readdata = ram[ram_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: result FIFO push/pop,
// overflow, full push+pop, RAM/unmapped access, alignment and async reset.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        overflow;
    logic        misalign;

    int vectors;
    int miscompares;

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataaddr  (dataaddr),
        .writedata (writedata),
        .readdata  (readdata),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .overflow  (overflow),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the store is captured at the next rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataaddr  = a;
        writedata = d;
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        dataaddr = a;
        #1;
        d = readdata;
    endtask

    logic [31:0] rd;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        memwrite    = 1'b0;
        dataaddr    = '0;
        writedata   = '0;
        res_ready   = 1'b0;

        #1;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_mis", 32'(misalign), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single push, then one-cycle pop
        store(32'd84, 32'd7);
        check("t1_valid", 32'(res_valid), 32'd1);
        check("t1_data", res_data, 32'd7);
        load(32'd88, rd);
        check("t1_status", rd, 32'h00000001);
        load(32'd84, rd);
        check("t1_load_head", rd, 32'd7);
        check("t1_no_pop", 32'(res_valid), 32'd1);
        pop_one();
        check("t1_pop_valid", 32'(res_valid), 32'd0);
        check("t1_pop_data", res_data, 32'd0);

        // Overflow and drain order
        for (int i = 1; i <= 5; i++) store(32'd84, 32'(i));
        check("t2_ovf", 32'(overflow), 32'd1);
        load(32'd88, rd);
        check("t2_status", rd, 32'h80000004);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t2_drain%0d", i), res_data, 32'(i));
            pop_one();
        end
        check("t2_empty", 32'(res_valid), 32'd0);
        store(32'd88, 32'd0);
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) store(32'd84, 32'(i));
        res_ready = 1'b1;
        store(32'd84, 32'd9);
        res_ready = 1'b0;
        check("t3_ovf", 32'(overflow), 32'd0);
        load(32'd88, rd);
        check("t3_status", rd, 32'h00000004);
        begin
            logic [31:0] exp_order [4];
            exp_order = '{32'd2, 32'd3, 32'd4, 32'd9};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_drain%0d", i), res_data, exp_order[i]);
                pop_one();
            end
        end
        check("t3_empty", 32'(res_valid), 32'd0);

        // RAM, boundary and unmapped accesses
        store(32'd80, 32'h12345678);
        load(32'd80, rd);
        check("t4_ram80", rd, 32'h12345678);
        store(32'd252, 32'hA5A5_5A5A);
        load(32'd252, rd);
        check("t4_ram252", rd, 32'hA5A5_5A5A);
        store(32'd256, 32'hDEADBEEF);
        load(32'd256, rd);
        check("t4_unmapped", rd, 32'd0);
        load(32'd80, rd);
        check("t4_ram80_kept", rd, 32'h12345678);
        check("t4_no_push", 32'(res_valid), 32'd0);

        // Pointer wrap: ten push/pop pairs
        for (int i = 0; i < 10; i++) begin
            store(32'd84, 32'd200 + 32'(i));
            check($sformatf("t5_head%0d", i), res_data, 32'd200 + 32'(i));
            pop_one();
        end
        check("t5_empty", 32'(res_valid), 32'd0);

        // Alignment
        store(32'd85, 32'd5);
`ifdef DMEM_ALIGN_CHECK_EN
        check("t6_no_push", 32'(res_valid), 32'd0);
        check("t6_mis", 32'(misalign), 32'd1);
        load(32'd81, rd);
        check("t6_mis_load", rd, 32'd0);
        store(32'd88, 32'd0);
        check("t6_mis_clr", 32'(misalign), 32'd0);
`else
        check("t6_push", 32'(res_valid), 32'd1);
        check("t6_data", res_data, 32'd5);
        check("t6_mis", 32'(misalign), 32'd0);
        load(32'd81, rd);
        check("t6_alias81", rd, 32'h12345678);
        pop_one();
`endif

        // Asynchronous reset mid-drain
        store(32'd84, 32'd11);
        store(32'd84, 32'd12);
        store(32'd84, 32'd13);
        load(32'd88, rd);
        check("t7_pre_count", rd, 32'h00000003);
        reset = 1'b0;
        #1;
        check("t7_valid", 32'(res_valid), 32'd0);
        check("t7_data", res_data, 32'd0);
        load(32'd88, rd);
        check("t7_count", rd, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        store(32'd84, 32'd7);
        check("t7_after_valid", 32'(res_valid), 32'd1);
        check("t7_after_head", res_data, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS core's data bus (`memwrite`, `dataaddr`, `writedata`, `readdata`). It is the memory side of the bus the processor drives. It provides word RAM and a memory-mapped result port. Stores to the result address are queued in a small FIFO and drained over a valid/ready handshake, so pass/fail results leave the core in hardware instead of being sniffed by a bench. It sits beside the core inside `top`.

## Interface
- `DEPTH_WORDS`, 64: RAM size in 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, 2..128.
- `RESULT_ADDR`, 32'h54: byte address of the result port.
- `STATUS_ADDR`, 32'h58: byte address of the status register.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  store strobe from the core.
- `dataaddr`  in  32  byte address from the core.
- `writedata`  in  32  store data.
- `readdata`  out  32  load data; combinational from `dataaddr`.
- `res_valid`  out  1  FIFO head valid.
- `res_data`  out  32  FIFO head; 0 when empty.
- `res_ready`  in  1  consumer accepts head.
- `overflow`  out  1  sticky: a result push was dropped.
- `misalign`  out  1  sticky misaligned-store flag; tied 0 without `DMEM_ALIGN_CHECK_EN`.

## Operation
- Address decode priority: RESULT_ADDR, then STATUS_ADDR, then RAM range, then unmapped.
- RAM store: `memwrite` with an in-range address writes RAM[dataaddr[31:2]] at the edge.
- Out-of-range or unmapped stores are ignored.
- RAM contents are not reset.
- Loads:
  - RAM range returns the word.
  - RESULT_ADDR returns the head, or 0 if empty. A load never pops.
  - STATUS_ADDR returns {overflow, misalign, 22'b0, count[7:0]}, where count is the current occupancy.
  - Unmapped addresses return 0.
- Result push: a store to RESULT_ADDR enqueues `writedata`.
- FIFO ring: read pointer, write pointer and count register. Pointers wrap modulo FIFO_DEPTH.
- Pop: `res_valid && res_ready` at an edge pops the head.
- Full (count == FIFO_DEPTH) and push:
  - Without a pop in the same cycle, the push is dropped and `overflow` is set.
  - With a pop in the same cycle, both are performed; count is unchanged and the new entry lands at the tail.
- Empty and pop: impossible, since `res_valid` = 0.
- Push while empty: the entry becomes the head at the next edge. There is no bypass.
- Status store: any store to STATUS_ADDR clears `overflow` and `misalign`.
  - If a drop occurs in the same cycle, set wins.

## Timing
- Reset asserted, immediately and asynchronously:
  - count = 0, pointers = 0.
  - `res_valid` = 0, `res_data` = 0.
  - `overflow` = 0, `misalign` = 0.
  - FIFO contents are discarded.
- Reset asserted mid-drain: `res_valid` drops without waiting for an edge. Entries are lost.
- Push latency: a store captured at edge N gives `res_valid` = 1 after edge N, with `res_data` = the pushed value.
- Pop: the head advances after the accepting edge. `res_valid` falls after the edge that pops the last entry.
- `readdata` is purely combinational from `dataaddr` and current state. A store at edge N is visible to loads after edge N.
- Sustained throughput: one push and one pop per cycle.
- `res_data` and `res_valid` are stable while `res_ready` = 0. They change only on a push-into-empty, a pop, or reset.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A store with `dataaddr[1:0]` != 0 to any address is ignored: no RAM write, no push.
  - `misalign` is set.
  - Misaligned loads return 0.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - `dataaddr[1:0]` is ignored everywhere, so 81 decodes as 80.
  - RESULT_ADDR and STATUS_ADDR decode on bits [31:2] only.
  - `misalign` is constant 0.

## Test plan
- Single result push:
  - Stimulus: release reset; store 7 to 84 with `res_ready` = 0.
  - Response: after the edge, `res_valid` = 1, `res_data` = 7, load of 88 returns 32'h00000001.
  - Then raise `res_ready` for one cycle: `res_valid` = 0, `res_data` = 0.
- Overflow and drain order:
  - Stimulus: store 1, 2, 3, 4, 5 to 84 on consecutive cycles with `res_ready` = 0.
  - Response: count = 4, `overflow` = 1, load of 88 = 32'h80000004.
  - Draining yields 1, 2, 3, 4.
  - A store to 88 then clears `overflow`.
- Full with simultaneous push and pop:
  - Stimulus: fill with 1..4; store 9 to 84 with `res_ready` = 1.
  - Response: `overflow` stays 0, count stays 4, drain order is 2, 3, 4, 9.
- RAM and unmapped accesses:
  - Store 32'h12345678 to 80: load 80 returns 32'h12345678.
  - Store to 256 (DEPTH_WORDS = 64): ignored, load 256 returns 0.
  - Pointer wrap: 10 push/pop pairs preserve order.
- Alignment:
  - With `DMEM_ALIGN_CHECK_EN`, store 5 to 85: no push, `misalign` = 1.
  - Without `DMEM_ALIGN_CHECK_EN`, the same store pushes 5.
- Asynchronous reset:
  - Stimulus: FIFO holds 3 entries; assert `reset` low between edges.
  - Response: `res_valid` = 0 and count = 0 before the next edge.
  - After release, a store of 7 to 84 gives head = 7.
